alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter and sequencer sharing one combinational ALU
//
// Optional feature macro: ALU_ARB_FUNC_CHECK_EN (reject ALU codes 3'b011/3'b101 with rsp_err)
//
// Ports:
//   clk, reset_n           clock (rising edge), synchronous active-low reset
//   req_valid/req_ready    per-requester request handshake (ready is one-hot or zero)
//   req_a/req_b/req_f      packed per-requester operands and function code
//   alu_a/alu_b/alu_f      to the shared ALU, always driven from the op registers
//   alu_y/alu_zero         from the shared ALU
//   rsp_valid/rsp_ready    one-hot response valid addressed to the owner, consumer accept
//   rsp_y/rsp_zero/rsp_err registered result, zero flag and illegal-function flag
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]     req_f,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_f,
    input  logic [WIDTH-1:0]         alu_y,
    input  logic                     alu_zero,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_y,
    output logic                     rsp_zero,
    output logic                     rsp_err
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     owner_q;
    logic [WIDTH-1:0]  op_a_q;
    logic [WIDTH-1:0]  op_b_q;
    logic [2:0]        op_f_q;
    logic [WIDTH-1:0]  rsp_y_q;
    logic              rsp_zero_q;
    logic              rsp_err_q;

    logic              found;
    logic [PW-1:0]     winner;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic [2:0]        sel_f;
    logic              sel_illegal;

    // Search from ptr upward with wrap; iterating from the farthest offset
    // down lets the closest valid requester overwrite the others.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                found  = 1'b1;
                winner = PW'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_f = 3'b000;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == PW'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
                sel_f = req_f[i*3 +: 3];
            end
        end
    end

`ifdef ALU_ARB_FUNC_CHECK_EN
    // Codes the ALU does not implement are answered directly with an error.
    assign sel_illegal = (sel_f == 3'b011) || (sel_f == 3'b101);
`else
    assign sel_illegal = 1'b0;
`endif

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == S_RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_f_q     <= 3'b000;
            rsp_y_q    <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        owner_q <= winner;
                        if (sel_illegal) begin
                            rsp_y_q    <= '0;
                            rsp_zero_q <= 1'b0;
                            rsp_err_q  <= 1'b1;
                            state_q    <= S_RESP;
                        end else begin
                            op_a_q  <= sel_a;
                            op_b_q  <= sel_b;
                            op_f_q  <= sel_f;
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    rsp_y_q    <= alu_y;
                    rsp_zero_q <= alu_zero;
                    rsp_err_q  <= 1'b0;
                    state_q    <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        // The owner just served drops to lowest priority.
                        ptr_q   <= (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_a    = op_a_q;
    assign alu_b    = op_b_q;
    assign alu_f    = op_f_q;
    assign rsp_y    = rsp_y_q;
    assign rsp_zero = rsp_zero_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk;
    logic             reset_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N*3-1:0]   req_f;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [2:0]       alu_f;
    logic [W-1:0]     alu_y;
    logic             alu_zero;
    logic [N-1:0]     rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_y;
    logic             rsp_zero;
    logic             rsp_err;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    alu_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_f     (req_f),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .alu_y     (alu_y),
        .alu_zero  (alu_zero),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_alu(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        case (f)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b100:  return ~(a | b);
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a & b;
        endcase
    endfunction

    // Shared ALU stand-in.
    always_comb begin
        alu_y    = ref_alu(alu_f, alu_a, alu_b);
        alu_zero = (alu_y == '0);
    end

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int exp_winner();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_f[i*3 +: 3] = f;
        req_valid[i]    = 1'b1;
    endtask

    // One full transaction, entered at posedge+#1 in IDLE with requests set.
    task automatic run_txn(input int hold, input string tag, output int w);
        logic [W-1:0] ey;
        logic         ez;
        logic         ee;
        logic [2:0]   f;
        #1;
        w = exp_winner();
        chk({tag, "_ready"}, 64'(req_ready), 64'(oh(w)));
        if (w < 0) return;
        f  = req_f[w*3 +: 3];
        ee = 1'b0;
`ifdef ALU_ARB_FUNC_CHECK_EN
        ee = (f == 3'b011) || (f == 3'b101);
`endif
        ey = ee ? '0 : ref_alu(f, req_a[w*W +: W], req_b[w*W +: W]);
        ez = ee ? 1'b0 : (ey == '0);
        @(posedge clk); #1;
        req_valid[w] = 1'b0;
        chk({tag, "_ready_after_accept"}, 64'(req_ready), 64'(0));
        if (!ee) begin
            chk({tag, "_no_rsp_in_exec"}, 64'(rsp_valid), 64'(0));
            @(posedge clk); #1;
        end
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(oh(w)));
        chk({tag, "_rsp_y"}, 64'(rsp_y), 64'(ey));
        chk({tag, "_rsp_zero"}, 64'(rsp_zero), 64'(ez));
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(ee));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 64'(rsp_valid), 64'(oh(w)));
            chk({tag, "_hold_y"}, 64'(rsp_y), 64'(ey));
            chk({tag, "_hold_zero"}, 64'(rsp_zero), 64'(ez));
            chk({tag, "_hold_ready"}, 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        m_ptr = (w + 1) % N;
        chk({tag, "_rsp_done"}, 64'(rsp_valid), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_alu_a"}, 64'(alu_a), 64'(0));
        chk({tag, "_alu_b"}, 64'(alu_b), 64'(0));
        chk({tag, "_alu_f"}, 64'(alu_f), 64'(0));
        chk({tag, "_rsp_y"}, 64'(rsp_y), 64'(0));
        chk({tag, "_rsp_zero"}, 64'(rsp_zero), 64'(0));
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
    endtask

    initial begin
        int w;
        int order [5];
        order = '{0, 1, 2, 3, 0};
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_f     = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single ADD
        set_req(0, 32'd7, 32'd5, 3'b010);
        run_txn(0, "add", w);

        // Zero flag via SUB, then SLT
        set_req(1, 32'd9, 32'd9, 3'b110);
        run_txn(0, "sub_zero", w);
        set_req(2, 32'd3, 32'd4, 3'b111);
        run_txn(0, "slt", w);

        // Round-robin from ptr=0 with all requesters held valid
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_ptr = 0;
        for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 32'(10 * i), 3'b001);
        for (int r = 0; r < 5; r++) begin
            #1;
            chk("rr_order", 64'(req_ready), 64'(oh(order[r])));
            run_txn(0, "rr", w);
            set_req(w, 32'(r * 3 + 1), 32'(r), 3'b010);
        end
        req_valid = '0;

        // Backpressure
        set_req(1, 32'hF0F0_0000, 32'h0F0F_0000, 3'b100);
        run_txn(5, "bp", w);

        // Reset mid-operation
        set_req(2, 32'd100, 32'd1, 3'b010);
        #1;
        chk("midrst_grant", 64'(req_ready), 64'(oh(2)));
        @(posedge clk); #1;
        req_valid = '0;
        reset_n   = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        reset_n = 1'b1;
        m_ptr   = 0;
        set_req(3, 32'd1, 32'd2, 3'b010);
        set_req(1, 32'd8, 32'd2, 3'b110);
        #1;
        chk("midrst_next_grant", 64'(req_ready), 64'(oh(1)));
        run_txn(0, "midrst_txn", w);
        run_txn(0, "midrst_txn2", w);

        // Unimplemented code
        set_req(0, 32'd6, 32'd3, 3'b101);
        run_txn(0, "f101", w);
        set_req(3, 32'd6, 32'd3, 3'b011);
        run_txn(1, "f011", w);

        // Randomized traffic; valid requesters keep their operands stable
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    set_req(i, $urandom, ($urandom_range(0, 3) == 0) ? req_a[i*W +: W] : $urandom,
                            3'($urandom_range(0, 7)));
                end
            end
            if (req_valid == '0) begin
                set_req($urandom_range(0, N - 1), $urandom, $urandom, 3'($urandom_range(0, 7)));
            end
            run_txn($urandom_range(0, 2), "rand", w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
